// File: rtl/row_assembler_pkg.sv
// Pixel sensor configuration shared by the row assembly path.
// Geometry defaults and the output-stage state encoding.
package PixelSensorConfig;

  localparam int CFG_PIXEL_ARRAY_WIDTH  = 8;
  localparam int CFG_PIXEL_ARRAY_HEIGHT = 4;
  localparam int CFG_OUTPUT_BUS_WIDTH   = 2;
  localparam int CFG_PIXEL_BITS         = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/row_assembler_counter.sv
// Wrapping up-counter with synchronous clear.
// Clear and enable together count the enabled event as the first one.
module Counter #(
  parameter int              WIDTH = 1,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base    = clr_i ? '0 : count_q;
    wrap_o  = en_i && (base == MAX);
    count_d = base;
    if (en_i) begin
      count_d = wrap_o ? '0 : base + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = base;

endmodule

// File: rtl/row_assembler.sv
// Packs bus words into full pixel rows and hands them off through a
// one-deep valid/ready output register with sticky drop reporting.
module row_assembler
  import PixelSensorConfig::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = CFG_PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = CFG_PIXEL_ARRAY_HEIGHT,
  parameter int OUTPUT_BUS_WIDTH   = CFG_OUTPUT_BUS_WIDTH,
  parameter int PIXEL_BITS         = CFG_PIXEL_BITS,
  localparam int WPR = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1,
  localparam int RW  = (PIXEL_ARRAY_HEIGHT > 1) ?
                       $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int WB  = OUTPUT_BUS_WIDTH * PIXEL_BITS,
  localparam int RB  = PIXEL_ARRAY_WIDTH * PIXEL_BITS
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          BUS_VALID,
  input  logic [WB-1:0] BUS_DATA,
  input  logic          FRAME_SYNC,
  input  logic          ROW_READY,
  output logic          ROW_VALID,
  output logic [RB-1:0] ROW_DATA,
  output logic [RW-1:0] ROW_INDEX,
  output logic          FRAME_LAST,
  output logic          OVERFLOW
);

  localparam logic [CW-1:0] WORD_LAST = CW'(WPR - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(PIXEL_ARRAY_HEIGHT - 1);

  out_state_e    state_q, state_d;
  logic [RB-1:0] part_q, part_d;
  logic [RB-1:0] data_q, data_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] word_k;
  logic          row_done;
  logic [RB-1:0] part_base;
  logic [RB-1:0] assembled;
  logic [RW-1:0] row_base;
  logic          load;
  logic          drop;

  Counter #(
    .WIDTH (CW),
    .MAX   (WORD_LAST)
  ) u_word_cnt (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clr_i   (FRAME_SYNC),
    .en_i    (BUS_VALID),
    .count_o (word_k),
    .wrap_o  (row_done)
  );

  always_comb begin
    part_base = FRAME_SYNC ? '0 : part_q;
    row_base  = FRAME_SYNC ? '0 : row_q;
    assembled = part_base;
    assembled[int'(word_k)*WB +: WB] = BUS_DATA;

    part_d = part_base;
    if (row_done) begin
      part_d = '0;
    end else if (BUS_VALID) begin
      part_d = assembled;
    end

    row_d = row_base;
    if (row_done) begin
      row_d = (row_base == ROW_LAST) ? '0 : row_base + 1'b1;
    end

    load = row_done && ((state_q == ST_EMPTY) || ROW_READY);
    drop = row_done && (state_q == ST_FULL) && !ROW_READY;
    ovf_d = (FRAME_SYNC ? 1'b0 : ovf_q) | drop;

    data_d = data_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (load) begin
      data_d = assembled;
      idx_d  = row_base;
      last_d = (row_base == ROW_LAST);
    end

    state_d = state_q;
    unique case (1'b1)
      load:                                state_d = ST_FULL;
      (state_q == ST_FULL) && ROW_READY:   state_d = ST_EMPTY;
      default:                             state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      part_q  <= '0;
      data_q  <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      data_q  <= data_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ROW_VALID  = (state_q == ST_FULL);
  assign ROW_DATA   = data_q;
  assign ROW_INDEX  = idx_q;
  assign FRAME_LAST = last_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: doc/row_assembler.md
ROW_ASSEMBLER -- requirements
Module: row_assembler

Interface
REQ-001 The block SHALL have parameter PIXEL_ARRAY_WIDTH, default PixelSensorConfig value, pixels per row.
REQ-002 The block SHALL have parameter PIXEL_ARRAY_HEIGHT, default PixelSensorConfig value, rows per frame.
REQ-003 The block SHALL have parameter OUTPUT_BUS_WIDTH, default PixelSensorConfig value, pixels per bus word; must divide PIXEL_ARRAY_WIDTH.
REQ-004 The block SHALL have parameter PIXEL_BITS, default PixelSensorConfig value, bits per pixel.
REQ-005 The block SHALL use one clock, CLK (input, 1), all logic on its rising edge.
REQ-006 The block SHALL have RESET (input, 1), synchronous, active-high.
REQ-007 BUS_VALID (input, 1): the current BUS_DATA word is valid this cycle.
REQ-008 BUS_DATA (input, OUTPUT_BUS_WIDTH*PIXEL_BITS): one word of binary-coded pixels, pixel 0 in LSBs.
REQ-009 FRAME_SYNC (input, 1): one-cycle pulse marking the start of a new frame.
REQ-010 ROW_READY (input, 1): consumer accepts the row this cycle.
REQ-011 ROW_VALID (output, 1): ROW_DATA, ROW_INDEX and FRAME_LAST are valid.
REQ-012 ROW_DATA (output, PIXEL_ARRAY_WIDTH*PIXEL_BITS): assembled row, column 0 in LSBs.
REQ-013 ROW_INDEX (output, clog2(PIXEL_ARRAY_HEIGHT)): row number of ROW_DATA within the frame.
REQ-014 FRAME_LAST (output, 1): ROW_INDEX == PIXEL_ARRAY_HEIGHT-1.
REQ-015 OVERFLOW (output, 1): sticky, a completed row was dropped.

Function
REQ-016 WORDS_PER_ROW = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; the word counter SHALL be clog2(WORDS_PER_ROW) bits, minimum 1.
REQ-017 Each cycle with BUS_VALID=1, BUS_DATA SHALL be stored at word slot word_count, occupying row bits [(k+1)*W*B-1 : k*W*B] for k = word_count; the counter SHALL then increment.
REQ-018 Gaps (BUS_VALID=0) SHALL NOT affect the partial row or the word counter.
REQ-019 On the word with word_count == WORDS_PER_ROW-1, the word counter SHALL wrap to 0 and the row SHALL be complete.
REQ-020 The output stage SHALL be a two-state machine, EMPTY (ROW_VALID=0) and FULL (ROW_VALID=1).
REQ-021 A complete row SHALL be loaded into the output register when state is EMPTY or ROW_READY=1 that cycle; ROW_VALID then rises on the next cycle, a one-cycle latency from the final word.
REQ-022 FULL -> EMPTY SHALL occur on ROW_READY=1 with no row completing; with a row completing in the same cycle, state SHALL stay FULL with the new row loaded.
REQ-023 While FULL and ROW_READY=0, ROW_DATA, ROW_INDEX and FRAME_LAST SHALL hold stable.
REQ-024 A row completing while FULL and ROW_READY=0 SHALL be dropped and OVERFLOW set to 1; the held row SHALL be unchanged.
REQ-025 The row counter SHALL increment on every completed row, including dropped rows, and wrap from PIXEL_ARRAY_HEIGHT-1 to 0.
REQ-026 ROW_INDEX SHALL be the row counter value at row completion.
REQ-027 FRAME_SYNC SHALL clear the word counter, the row counter, the partial row and OVERFLOW; it SHALL NOT clear a row held in the output register.
REQ-028 If FRAME_SYNC and BUS_VALID are both high, the word SHALL be accepted as word 0 of row 0 of the new frame.
REQ-029 ROW_READY while EMPTY SHALL be ignored.

Reset
REQ-030 On RESET, ROW_VALID, ROW_DATA, ROW_INDEX, FRAME_LAST and OVERFLOW SHALL be 0, state EMPTY, and both counters and the partial row 0.
REQ-031 RESET mid-row or mid-handshake SHALL discard all data; RESET SHALL take priority over FRAME_SYNC and BUS_VALID.

Structure
REQ-032 PIXEL_ARRAY_WIDTH, PIXEL_ARRAY_HEIGHT, OUTPUT_BUS_WIDTH and PIXEL_BITS SHALL come from PixelSensorConfig; the EMPTY/FULL state enum SHALL be added to that package.
REQ-033 The existing Counter component SHALL be reused for the word counter; there are no other sub-modules.

Verification (W=4, H=4, BUS=2, B=8; WORDS_PER_ROW=2)
REQ-034 Test 1: reset, then ROW_READY=1 and words 0x2211 and 0x4433 on consecutive cycles -> the cycle after, ROW_VALID=1, ROW_DATA=0x44332211, ROW_INDEX=0.
REQ-035 Test 2: 4 rows back-to-back with ROW_READY=1 -> ROW_INDEX 0,1,2,3 in order; FRAME_LAST=1 only on index 3; the fifth row has index 0.
REQ-036 Test 3: 0x2211, then 3 idle cycles, then 0x4433 -> one row 0x44332211; no extra ROW_VALID.
REQ-037 Test 4: ROW_READY=0, two rows sent -> row 0 held stable, OVERFLOW=1; ROW_READY=1 for 1 cycle -> ROW_VALID=0; the next row has index 2.
REQ-038 Test 5: one word sent, then FRAME_SYNC together with word 0xAAAA, then 0xBBBB -> row 0xBBBBAAAA with index 0; OVERFLOW=0.
REQ-039 Test 6: RESET asserted while FULL and one word into the next row -> all outputs 0 next cycle; the following two words give a row with index 0.
